// File: rtl/bv_tcam_seg_engine.sv
// Bit-vector TCAM lookup engine: per-stride SRAM bit vectors are ANDed per
// segment, merged across segments by bus mode, then priority encoded.
`timescale 1ns/1ps
module bv_tcam_seg_engine #(
  parameter int STRIDE = 4,
  parameter int SRAM_NUM = 32,
  parameter int SEG_NUM = 4,
  parameter int MODE_WIDTH = 2,
  parameter int RESULT_WIDTH = 32,
  localparam int AW = STRIDE + MODE_WIDTH,
  localparam int IW = $clog2(RESULT_WIDTH),
  localparam int SW = $clog2(SRAM_NUM)
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [SW-1:0] cfg_sram_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [RESULT_WIDTH-1:0] cfg_data,
  input  logic din_val,
  input  logic [STRIDE*SRAM_NUM-1:0] din,
  input  logic [MODE_WIDTH-1:0] bus_mode,
  output logic dout_val,
  output logic [MODE_WIDTH-1:0] dout_mode,
  output logic [SEG_NUM-1:0] dout_hit,
  output logic [SEG_NUM*IW-1:0] dout_idx
);

  localparam int DEPTH = 1 << AW;
  localparam int PER = SRAM_NUM / SEG_NUM;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t state;
  logic [AW-1:0] cnt;
  logic clr;
  logic cfg_fire;
  logic look;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      cfg_ready <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (&cnt) begin
            state <= RUN;
            cfg_ready <= 1'b1;
          end
        end
        RUN: cfg_ready <= 1'b1;
        default: state <= CLEAR;
      endcase
    end
  end

  assign clr = (state == CLEAR);
  assign cfg_fire = cfg_valid & cfg_ready;
  assign look = din_val & cfg_ready;

  logic [RESULT_WIDTH-1:0] rd [SRAM_NUM];

  // Read-before-write: a same-cycle lookup sees the old word.
  for (genvar i = 0; i < SRAM_NUM; i++) begin : g_sram
    logic [RESULT_WIDTH-1:0] mem [DEPTH];
    logic [RESULT_WIDTH-1:0] q;
    logic we;
    logic [AW-1:0] wa;
    logic [RESULT_WIDTH-1:0] wd;
    logic [AW-1:0] ra;

    assign we = clr | (cfg_fire & (cfg_sram_sel == SW'(i)));
    assign wa = clr ? cnt : cfg_addr;
    assign wd = clr ? '0 : cfg_data;
    assign ra = {bus_mode, din[STRIDE*i +: STRIDE]};

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      q <= mem[ra];
    end

    assign rd[i] = q;
  end

  logic v1, v2, v3;
  logic [MODE_WIDTH-1:0] m1, m2, m3;
  logic [RESULT_WIDTH-1:0] seg_c [SEG_NUM];
  logic [RESULT_WIDTH-1:0] seg_q [SEG_NUM];
  logic [RESULT_WIDTH-1:0] mrg_c [SEG_NUM];
  logic [RESULT_WIDTH-1:0] mrg_q [SEG_NUM];
  logic [RESULT_WIDTH-1:0] all_and;
  logic [SEG_NUM-1:0] hit_c;
  logic [SEG_NUM*IW-1:0] idx_c;

  always_comb begin
    for (int g = 0; g < SEG_NUM; g++) begin
      seg_c[g] = '1;
      for (int k = 0; k < PER; k++)
        seg_c[g] &= rd[g*PER + k];
    end
  end

  always_comb begin
    all_and = '1;
    for (int h = 0; h < SEG_NUM; h++)
      all_and &= seg_q[h];
    for (int g = 0; g < SEG_NUM; g++) begin
      mrg_c[g] = all_and;
      unique case (1'b1)
        (m2 == MODE_WIDTH'(0)): mrg_c[g] = seg_q[g];
        (m2 == MODE_WIDTH'(1)):
          mrg_c[g] = seg_q[g & ~1]
                   & seg_q[(g & ~1) + ((SEG_NUM > 1) ? 1 : 0)];
        default: mrg_c[g] = all_and;
      endcase
    end
  end

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    hit_c = '0;
    idx_c = '0;
    for (int g = 0; g < SEG_NUM; g++) begin
      hit_c[g] = |mrg_q[g];
      for (int b = RESULT_WIDTH-1; b >= 0; b--)
        if (mrg_q[g][b]) idx_c[g*IW +: IW] = IW'(b);
    end
  end

  always_ff @(posedge clk) begin
    seg_q <= seg_c;
    mrg_q <= mrg_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      m1 <= '0;
      m2 <= '0;
      m3 <= '0;
      dout_val <= 1'b0;
      dout_mode <= '0;
      dout_hit <= '0;
      dout_idx <= '0;
    end else begin
      v1 <= look;
      v2 <= v1;
      v3 <= v2;
      m1 <= bus_mode;
      m2 <= m1;
      m3 <= m2;
      dout_val <= v3;
      dout_mode <= m3;
      dout_hit <= v3 ? hit_c : '0;
      dout_idx <= v3 ? idx_c : '0;
    end
  end

endmodule

// File: tb/tb_bv_tcam_seg_engine.sv
// Bench for bv_tcam_seg_engine: directed vectors plus a cycle model of the
// lookup function, clear sweep and 4-cycle latency.
`timescale 1ns/1ps
module tb_bv_tcam_seg_engine;

  localparam int STRIDE = 4;
  localparam int SRAM_NUM = 32;
  localparam int SEG_NUM = 4;
  localparam int MODE_WIDTH = 2;
  localparam int RW = 32;
  localparam int AW = 6;
  localparam int IW = 5;
  localparam int SW = 5;
  localparam int PER = SRAM_NUM / SEG_NUM;
  localparam int DEPTH = 64;
  localparam int KW = STRIDE * SRAM_NUM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [SW-1:0] cfg_sram_sel = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [RW-1:0] cfg_data = '0;
  logic din_val = 1'b0;
  logic [KW-1:0] din = '0;
  logic [MODE_WIDTH-1:0] bus_mode = '0;
  logic dout_val;
  logic [MODE_WIDTH-1:0] dout_mode;
  logic [SEG_NUM-1:0] dout_hit;
  logic [SEG_NUM*IW-1:0] dout_idx;

  always #5 clk = ~clk;

  bv_tcam_seg_engine dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sram_sel(cfg_sram_sel),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .din_val(din_val),
    .din(din),
    .bus_mode(bus_mode),
    .dout_val(dout_val),
    .dout_mode(dout_mode),
    .dout_hit(dout_hit),
    .dout_idx(dout_idx)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic v;
    logic [MODE_WIDTH-1:0] mode;
    logic [SEG_NUM-1:0] hit;
    logic [SEG_NUM*IW-1:0] idx;
  } exp_t;

  logic [RW-1:0] mem_m [SRAM_NUM][DEPTH];
  exp_t sh [4];
  bit ready_m = 1'b0;
  int sweep_m = 0;
  bit check_en = 1'b0;

  function automatic exp_t predict(input logic [KW-1:0] key,
                                   input logic [MODE_WIDTH-1:0] mode);
    exp_t r;
    logic [RW-1:0] v [SEG_NUM];
    logic [RW-1:0] m;
    int gs, base, a, s;
    bit found;
    r = '0;
    r.v = 1'b1;
    r.mode = mode;
    for (int g = 0; g < SEG_NUM; g++) begin
      v[g] = '1;
      for (int k = 0; k < PER; k++) begin
        s = g * PER + k;
        a = int'(mode) * 16 + int'(key[STRIDE*s +: STRIDE]);
        v[g] &= mem_m[s][a];
      end
    end
    gs = (mode == 0) ? 1 : (mode == 1) ? 2 : SEG_NUM;
    for (int g = 0; g < SEG_NUM; g++) begin
      base = (g / gs) * gs;
      m = '1;
      for (int h = base; h < base + gs; h++) m &= v[h];
      found = 1'b0;
      for (int b = 0; b < RW; b++)
        if (m[b] && !found) begin
          found = 1'b1;
          r.hit[g] = 1'b1;
          r.idx[g*IW +: IW] = IW'(b);
        end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t n;
    if (rst) begin
      ready_m = 1'b0;
      sweep_m = 0;
      for (int i = 0; i < 4; i++) sh[i] = '0;
      for (int s = 0; s < SRAM_NUM; s++)
        for (int a = 0; a < DEPTH; a++) mem_m[s][a] = '0;
    end else begin
      n = '0;
      if (ready_m && din_val) n = predict(din, bus_mode);
      if (ready_m && cfg_valid) mem_m[cfg_sram_sel][cfg_addr] = cfg_data;
      sh[3] = sh[2];
      sh[2] = sh[1];
      sh[1] = sh[0];
      sh[0] = n;
      if (!ready_m) begin
        sweep_m++;
        if (sweep_m == DEPTH) ready_m = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cfg_ready", 64'(cfg_ready), 64'(ready_m));
      check("dout_val", 64'(dout_val), 64'(sh[3].v));
      check("dout_hit", 64'(dout_hit), 64'(sh[3].hit));
      check("dout_idx", 64'(dout_idx), 64'(sh[3].idx));
      if (sh[3].v) check("dout_mode", 64'(dout_mode), 64'(sh[3].mode));
    end
  end

  bit collect = 1'b0;
  int ncyc = 0;
  int first_v = -1;
  int last_v = -1;
  logic [MODE_WIDTH-1:0] got_modes [$];

  always @(negedge clk) begin
    ncyc++;
    if (collect && dout_val) begin
      got_modes.push_back(dout_mode);
      if (first_v < 0) first_v = ncyc;
      last_v = ncyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int s, input int a, input logic [RW-1:0] d);
    cfg_valid = 1'b1;
    cfg_sram_sel = SW'(s);
    cfg_addr = AW'(a);
    cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic sweep_wait(output int cyc, output int seen);
    cyc = 0;
    seen = 0;
    while (!cfg_ready && cyc < 200) begin
      tick();
      cyc++;
      if (dout_val) seen++;
    end
  endtask

  task automatic lookup_once(input logic [KW-1:0] key,
                             input logic [MODE_WIDTH-1:0] mode,
                             output int lat,
                             output logic [SEG_NUM-1:0] hit,
                             output logic [SEG_NUM*IW-1:0] idx);
    din = key;
    bus_mode = mode;
    din_val = 1'b1;
    tick();
    din_val = 1'b0;
    lat = 0;
    hit = '0;
    idx = '0;
    for (int j = 1; j <= 10 && lat == 0; j++) begin
      tick();
      if (dout_val) begin
        lat = j + 1;
        hit = dout_hit;
        idx = dout_idx;
      end
    end
  endtask

  function automatic logic [KW-1:0] mk_key(input int seed);
    logic [KW-1:0] k;
    k = '0;
    for (int s = 0; s < SRAM_NUM; s++)
      k[STRIDE*s +: STRIDE] = STRIDE'((s * 7 + seed) % 16);
    return k;
  endfunction

  function automatic int nib(input logic [KW-1:0] k, input int s);
    return int'(k[STRIDE*s +: STRIDE]);
  endfunction

  logic [KW-1:0] key;
  logic [MODE_WIDTH-1:0] sent_modes [32];
  int lat, cyc, seen;
  logic [SEG_NUM-1:0] hit_a, hit_b;
  logic [SEG_NUM*IW-1:0] idx_a, idx_b;
  logic [RW-1:0] wd;

  initial begin
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("reset_dout_val", 64'(dout_val), 64'd0);
    check("reset_cfg_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    din = mk_key(1);
    din_val = 1'b1;
    sweep_wait(cyc, seen);
    din_val = 1'b0;
    repeat (6) begin
      tick();
      if (dout_val) seen++;
    end
    check("sweep_len", 64'(cyc), 64'd64);
    check("sweep_drop", 64'(seen), 64'd0);

    key = mk_key(3);
    for (int s = 0; s < SRAM_NUM; s++)
      cfg_wr(s, nib(key, s), (s < 8) ? 32'h0000_0010 : 32'hFFFF_FFFF);
    lookup_once(key, 2'd0, lat, hit_a, idx_a);
    check("m0_latency", 64'(lat), 64'd4);
    check("m0_hit", 64'(hit_a), 64'hF);
    check("m0_idx", 64'(idx_a), 64'h00004);

    for (int s = 0; s < SRAM_NUM; s++) begin
      wd = 32'hFFFF_FFFF;
      if (s == 0) wd = 32'h0000_00F0;
      if (s == 24) wd = 32'h0000_0300;
      cfg_wr(s, 32 + nib(key, s), wd);
    end
    lookup_once(key, 2'd2, lat, hit_a, idx_a);
    check("m2_latency", 64'(lat), 64'd4);
    check("m2_hit", 64'(hit_a), 64'h0);
    check("m2_idx", 64'(idx_a), 64'h0);

    for (int s = 0; s < SRAM_NUM; s++)
      cfg_wr(s, 16 + nib(key, s), (s == 0) ? 32'h4 : 32'hFFFF_FFFF);
    din = key;
    bus_mode = 2'd1;
    din_val = 1'b1;
    cfg_valid = 1'b1;
    cfg_sram_sel = '0;
    cfg_addr = AW'(16 + nib(key, 0));
    cfg_data = 32'h8;
    tick();
    cfg_valid = 1'b0;
    tick();
    din_val = 1'b0;
    tick();
    tick();
    check("wr_old_val", 64'(dout_val), 64'd1);
    hit_a = dout_hit;
    idx_a = dout_idx;
    tick();
    check("wr_new_val", 64'(dout_val), 64'd1);
    hit_b = dout_hit;
    idx_b = dout_idx;
    check("wr_old_hit", 64'(hit_a), 64'hF);
    check("wr_old_idx", 64'(idx_a), 64'h00042);
    check("wr_new_idx", 64'(idx_b), 64'h00063);

    cfg_valid = 1'b1;
    for (int s = 0; s < SRAM_NUM; s++)
      for (int a = 0; a < DEPTH; a++) begin
        cfg_sram_sel = SW'(s);
        cfg_addr = AW'(a);
        cfg_data = ~((32'd1 << $urandom_range(0, 31))
                   | (32'd1 << $urandom_range(0, 31)));
        tick();
      end
    cfg_valid = 1'b0;

    collect = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sent_modes[i] = MODE_WIDTH'((i * 5 + i / 3) % 4);
      bus_mode = sent_modes[i];
      din = {$urandom, $urandom, $urandom, $urandom};
      din_val = 1'b1;
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_sram_sel = SW'($urandom_range(0, SRAM_NUM - 1));
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_data = $urandom | $urandom;
      tick();
    end
    din_val = 1'b0;
    cfg_valid = 1'b0;
    repeat (8) tick();
    collect = 1'b0;
    check("burst_count", 64'(got_modes.size()), 64'd32);
    check("burst_span", 64'(last_v - first_v), 64'd31);
    for (int i = 0; i < 32; i++)
      if (i < got_modes.size())
        check("burst_mode", 64'(got_modes[i]), 64'(sent_modes[i]));

    din = mk_key(5);
    din_val = 1'b1;
    repeat (3) tick();
    din_val = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_dout_val", 64'(dout_val), 64'd0);
    sweep_wait(cyc, seen);
    repeat (5) begin
      tick();
      if (dout_val) seen++;
    end
    check("resweep_len", 64'(cyc), 64'd64);
    check("flush_drop", 64'(seen), 64'd0);
    lookup_once(mk_key(3), 2'd0, lat, hit_a, idx_a);
    check("cleared_latency", 64'(lat), 64'd4);
    check("cleared_hit", 64'(hit_a), 64'h0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
